alu_8bit: RTL and testbench
===========================

Name: alu_8bit

Overview:
- Registered 8-bit arithmetic/logic unit for the datapath: takes two operands and a 3-bit opcode, and produces a result plus carry, overflow and zero flags.
- Result and flags are computed combinationally and captured in output registers.
- Latency is one clock.
- A simple valid strobe qualifies inputs and outputs.

Parameters:
- WIDTH, 8, operand/result width in bits. All values in this spec assume 8; the logic must scale with WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  a, b and op are valid this cycle; capture the result
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- op  input  3  opcode
- out_valid  output  1  y and flags hold a fresh result (registered)
- y  output  WIDTH  result (registered)
- carry  output  1  carry/borrow/shift-out flag (registered)
- overflow  output  1  two's-complement overflow flag (registered)
- zero  output  1  high when y == 0 (registered)

Behaviour:
- Reset (asynchronous, rst=1): y=0, carry=0, overflow=0, zero=0, out_valid=0.
  - Held while rst is high.
  - Deasserting reset mid-stream drops any in-flight result.
- Latency: when in_valid=1 at rising edge N, the result appears at edge N with out_valid=1 after that edge. Back-to-back inputs are accepted every cycle.
- When in_valid=0 at an edge: out_valid clears to 0; y and the flags hold their previous values.
- Opcodes (op=000 through 111):
  - 000 ADD: y = a+b (mod 2^WIDTH); carry = carry out of the MSB; overflow = a and b share a sign and y's sign differs.
  - 001 SUB: y = a-b (mod 2^WIDTH); carry = borrow, i.e. 1 iff a < b unsigned; overflow = a and b differ in sign and y's sign differs from a.
  - 010 AND: y = a & b.
  - 011 OR: y = a | b.
  - 100 XOR: y = a ^ b.
  - 101 SHL: y = a << 1 with LSB filled 0; carry = a[MSB]; b ignored.
  - 110 SHR (logical): y = a >> 1 with MSB filled 0; carry = a[0]; b ignored.
  - 111 SLT (signed): y = 1 if a < b as two's complement, else 0; carry=0.
- carry is 0 for AND/OR/XOR/SLT.
- overflow is 0 for every op except ADD/SUB.
- zero = (y == 0) for every op, evaluated on the same-cycle result and registered together with y.
- Purely combinational compute path: no internal state other than the output registers.
- X/undefined op values are not supported. All 8 codes are defined, so no default/illegal case exists.

Test Plan:
- Reset: assert rst mid-operation -> out_valid=0, y=0, all flags 0 immediately, without waiting for a clock edge.
- ADD boundary cases, each checked one cycle after in_valid:
  - 0+0 -> y=0, zero=1, carry=0, overflow=0
  - 127+1 -> y=128, overflow=1, carry=0
  - 200+55 -> y=255, carry=0, overflow=0
  - 200+56 -> y=0, carry=1, zero=1
- SUB cases:
  - 15-1 -> y=14, carry=0
  - 127-1 -> y=126
  - 200-55 -> y=145, overflow=0
  - 0-1 -> y=255, carry=1
  - 128-1 -> y=127, overflow=1
- Logic ops with a=200, b=55: AND -> 0 with zero=1; OR -> 255; XOR -> 255. All with carry=0 and overflow=0.
- Shifts/SLT:
  - SHL 200 -> y=144, carry=1
  - SHR 200 -> y=100, carry=0
  - SHR 15 -> y=7, carry=1
  - SLT a=200, b=55 -> y=1
  - SLT a=15, b=1 -> y=0, zero=1
- Streaming: sweep all 8 ops across vector pairs (0,0), (15,1), (127,1), (200,55) with in_valid held high -> each result appears exactly one cycle later. Then drop in_valid -> out_valid=0, and y/flags hold their last values.

Source files
------------

// File: rtl/alu_8bit.sv
// Registered ALU: combinational add/sub/logic/shift/compare path feeding
// a single bank of output registers (result, carry, overflow, zero, valid).
module alu_8bit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  output logic [WIDTH-1:0] y,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_SLT = 3'b111
  } alu_op_e;

  localparam int unsigned MSB = WIDTH - 1;

  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic [WIDTH-1:0] y_next;
  logic             carry_next;
  logic             overflow_next;
  logic             slt;

  // Extended-width add/sub: bit WIDTH is carry-out for add and borrow for sub.
  assign sum_ext  = {1'b0, a} + {1'b0, b};
  assign diff_ext = {1'b0, a} - {1'b0, b};
  assign slt      = $signed(a) < $signed(b);

  always_comb begin
    y_next        = '0;
    carry_next    = 1'b0;
    overflow_next = 1'b0;
    case (alu_op_e'(op))
      OP_ADD: begin
        y_next        = sum_ext[WIDTH-1:0];
        carry_next    = sum_ext[WIDTH];
        overflow_next = (a[MSB] == b[MSB]) && (sum_ext[MSB] != a[MSB]);
      end
      OP_SUB: begin
        y_next        = diff_ext[WIDTH-1:0];
        carry_next    = diff_ext[WIDTH];
        overflow_next = (a[MSB] != b[MSB]) && (diff_ext[MSB] != a[MSB]);
      end
      OP_AND: y_next = a & b;
      OP_OR:  y_next = a | b;
      OP_XOR: y_next = a ^ b;
      OP_SHL: begin
        y_next     = {a[WIDTH-2:0], 1'b0};
        carry_next = a[MSB];
      end
      OP_SHR: begin
        y_next     = {1'b0, a[WIDTH-1:1]};
        carry_next = a[0];
      end
      OP_SLT: y_next = {{(WIDTH-1){1'b0}}, slt};
      default: y_next = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      y         <= '0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        y        <= y_next;
        carry    <= carry_next;
        overflow <= overflow_next;
        zero     <= (y_next == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_8bit.sv
// Directed bench for alu_8bit: reset, boundary vectors, back-to-back sweep
// of every opcode, and hold behaviour once in_valid drops.
module tb_alu_8bit;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] op;
  logic       out_valid;
  logic [7:0] y;
  logic       carry;
  logic       overflow;
  logic       zero;

  int checks = 0;
  int errors = 0;

  alu_8bit #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .op(op),
    .out_valid(out_valid), .y(y), .carry(carry), .overflow(overflow),
    .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic ev, input logic [7:0] ey,
                         input logic ec, input logic eo, input logic ez);
    chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, ev});
    chk({tag, ".y"},     {24'd0, y},         {24'd0, ey});
    chk({tag, ".carry"}, {31'd0, carry},     {31'd0, ec});
    chk({tag, ".ovf"},   {31'd0, overflow},  {31'd0, eo});
    chk({tag, ".zero"},  {31'd0, zero},      {31'd0, ez});
  endtask

  // Drive one valid vector at the falling edge; check one step after the next rising edge.
  task automatic step(input string tag, input logic [2:0] o, input logic [7:0] va,
                      input logic [7:0] vb, input logic [7:0] ey, input logic ec,
                      input logic eo, input logic ez);
    @(negedge clk);
    op = o; a = va; b = vb; in_valid = 1'b1;
    @(posedge clk);
    #1;
    chk_all(tag, 1'b1, ey, ec, eo, ez);
  endtask

  logic [7:0]  va_tab [4];
  logic [7:0]  vb_tab [4];
  logic [10:0] exp_tab [32];

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    va_tab = '{8'd0, 8'd15, 8'd127, 8'd200};
    vb_tab = '{8'd0, 8'd1,  8'd1,   8'd55};
    // {y, carry, overflow, zero}, ops ADD..SLT per operand pair
    exp_tab = '{
      {8'd0,  3'b001}, {8'd0,   3'b001}, {8'd0,   3'b001}, {8'd0,   3'b001},
      {8'd0,  3'b001}, {8'd0,   3'b001}, {8'd0,   3'b001}, {8'd0,   3'b001},
      {8'd16, 3'b000}, {8'd14,  3'b000}, {8'd1,   3'b000}, {8'd15,  3'b000},
      {8'd14, 3'b000}, {8'd30,  3'b000}, {8'd7,   3'b100}, {8'd0,   3'b001},
      {8'd128,3'b010}, {8'd126, 3'b000}, {8'd1,   3'b000}, {8'd127, 3'b000},
      {8'd126,3'b000}, {8'd254, 3'b000}, {8'd63,  3'b100}, {8'd0,   3'b001},
      {8'd255,3'b000}, {8'd145, 3'b000}, {8'd0,   3'b001}, {8'd255, 3'b000},
      {8'd255,3'b000}, {8'd144, 3'b100}, {8'd100, 3'b000}, {8'd1,   3'b000}
    };

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0;
    #1;
    chk_all("reset", 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    step("add_0_0",     3'd0, 8'd0,   8'd0,  8'd0,   1'b0, 1'b0, 1'b1);
    step("add_127_1",   3'd0, 8'd127, 8'd1,  8'd128, 1'b0, 1'b1, 1'b0);
    step("add_200_55",  3'd0, 8'd200, 8'd55, 8'd255, 1'b0, 1'b0, 1'b0);
    step("add_200_56",  3'd0, 8'd200, 8'd56, 8'd0,   1'b1, 1'b0, 1'b1);
    step("sub_15_1",    3'd1, 8'd15,  8'd1,  8'd14,  1'b0, 1'b0, 1'b0);
    step("sub_127_1",   3'd1, 8'd127, 8'd1,  8'd126, 1'b0, 1'b0, 1'b0);
    step("sub_200_55",  3'd1, 8'd200, 8'd55, 8'd145, 1'b0, 1'b0, 1'b0);
    step("sub_0_1",     3'd1, 8'd0,   8'd1,  8'd255, 1'b1, 1'b0, 1'b0);
    step("sub_128_1",   3'd1, 8'd128, 8'd1,  8'd127, 1'b0, 1'b1, 1'b0);
    step("and_200_55",  3'd2, 8'd200, 8'd55, 8'd0,   1'b0, 1'b0, 1'b1);
    step("or_200_55",   3'd3, 8'd200, 8'd55, 8'd255, 1'b0, 1'b0, 1'b0);
    step("xor_200_55",  3'd4, 8'd200, 8'd55, 8'd255, 1'b0, 1'b0, 1'b0);
    step("shl_200",     3'd5, 8'd200, 8'd99, 8'd144, 1'b1, 1'b0, 1'b0);
    step("shr_200",     3'd6, 8'd200, 8'd99, 8'd100, 1'b0, 1'b0, 1'b0);
    step("shr_15",      3'd6, 8'd15,  8'd0,  8'd7,   1'b1, 1'b0, 1'b0);
    step("slt_200_55",  3'd7, 8'd200, 8'd55, 8'd1,   1'b0, 1'b0, 1'b0);
    step("slt_15_1",    3'd7, 8'd15,  8'd1,  8'd0,   1'b0, 1'b0, 1'b1);

    // Reset asserted mid-cycle with a new vector in flight.
    step("pre_reset",   3'd0, 8'd100, 8'd27, 8'd127, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    op = 3'd0; a = 8'd100; b = 8'd100; in_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk_all("async_rst", 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk_all("rst_held", 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk_all("post_rst", 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);

    // Back-to-back sweep: in_valid stays high across all 32 vectors.
    for (int p = 0; p < 4; p++) begin
      for (int o = 0; o < 8; o++) begin
        step($sformatf("stream_p%0d_op%0d", p, o), 3'(o), va_tab[p], vb_tab[p],
             exp_tab[p*8+o][10:3], exp_tab[p*8+o][2], exp_tab[p*8+o][1],
             exp_tab[p*8+o][0]);
      end
    end

    @(negedge clk);
    in_valid = 1'b0; op = 3'd0; a = 8'd3; b = 8'd4;
    @(posedge clk);
    #1;
    chk_all("idle_hold", 1'b0, 8'd1, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk_all("idle_hold2", 1'b0, 8'd1, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
